button_edge_conditioner: RTL and testbench
==========================================

Name: button_edge_conditioner

Overview:
- Input conditioning stage for the board push-buttons (btnC/U/L/R/D), placed directly upstream of the LED-shift and toggle logic.
- Synchronises each raw asynchronous button, debounces it, and emits clean debounced levels plus one-cycle press and release pulses.
- Downstream logic consumes the press pulses directly and needs no edge detection of its own.

Parameters:
- N_BTN, 5, number of independent button channels (bit 0 = btnC, 1 = btnU, 2 = btnL, 3 = btnR, 4 = btnD).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a change (10 ms at 100 MHz); legal values are >= 2.
- REPEAT_DELAY, 50000000, HELD cycles before the first auto-repeat pulse (0.5 s); used only with AUTOREPEAT_EN.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (0.1 s); used only with AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  N_BTN  raw button pins, asynchronous to clk, active-high.
- btn_level  output  N_BTN  debounced button level, registered.
- btn_press  output  N_BTN  one-cycle pulse on an accepted 0->1 change (and on auto-repeat when enabled).
- btn_release  output  N_BTN  one-cycle pulse on an accepted 1->0 change.
- any_press  output  1  registered OR of btn_press, aligned with btn_press.

Behaviour:
- Reset (rst_n = 0, asynchronous): all outputs 0, sync flops 0, counters 0, every channel in IDLE. Release is synchronous in effect: the first active edge after rst_n rises performs normal operation.
- Synchronisation: 2-flop synchroniser per channel; s = second flop. The FSM only ever reads s.
- Channels are fully independent. Each has its own FSM and counter of width $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1.
- IDLE (level 0): if s = 1, go to PRESS_WAIT with cnt = 0.
- PRESS_WAIT:
  - if s = 0, return to IDLE, with no pulse (glitch rejected);
  - else, if cnt == DEBOUNCE_CYCLES-1, go to HELD, set btn_level = 1, pulse btn_press;
  - otherwise cnt++.
- HELD (level 1): if s = 0, go to RELEASE_WAIT with cnt = 0.
- RELEASE_WAIT:
  - if s = 1, return to HELD, with no pulse;
  - else, if cnt == DEBOUNCE_CYCLES-1, go to IDLE, set btn_level = 0, pulse btn_release;
  - otherwise cnt++.
- Latency: with raw held high from clock edge 0, btn_press and btn_level go high after edge DEBOUNCE_CYCLES+2. The release path has the same latency.
- Pulses last exactly one cycle and are registered (no combinational path from btn_raw).
- Press and release are never asserted together on the same channel.
- Simultaneous presses on several channels produce simultaneous pulses, with no priority or arbitration.
- Counter never wraps: it is cleared on every state entry and saturates logically at the compare value.
- Reset mid-debounce discards the partial count, with no pulse emitted.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - the HELD state counts cycles;
  - at REPEAT_DELAY-1 it pulses btn_press and reloads cnt = 0 with the period phase set;
  - thereafter it pulses every REPEAT_PERIOD cycles while s stays 1;
  - entering RELEASE_WAIT clears the repeat phase, and a bounce back to HELD restarts the delay from 0;
  - btn_release behaviour is unchanged.
- Undefined: HELD ignores time, there is exactly one btn_press per accepted press, and the REPEAT_* parameters are unused.

Test Plan:
- DEBOUNCE_CYCLES = 4, raw[3] rises at edge 0 and stays high → btn_press[3] = 1 only in the cycle after edge 6, btn_level[3] = 1 from edge 6, any_press pulses together with btn_press[3].
- DEBOUNCE_CYCLES = 4, raw[2] high for 3 cycles then low → no btn_press, btn_level stays 0.
- Bounce raw[2] 1,0,1,1,1,1,1 → exactly one btn_press, 4 stable cycles after the last 0 is absorbed; the same bounce on release gives exactly one btn_release.
- raw[2] and raw[3] rise on the same edge → btn_press[2] and btn_press[3] pulse in the same cycle; any_press is a single one-cycle pulse.
- rst_n pulled low mid-PRESS_WAIT, then released with raw still high → all outputs 0 during reset, and the full 4+2 edge latency restarts after release.
- AUTOREPEAT_EN, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, hold raw[4] for 30 cycles → initial press pulse, then repeat pulses 10 cycles after entering HELD and every 3 cycles after that; no further pulses once released, then one btn_release.

Source files
------------

// File: rtl/button_edge_conditioner.sv
// Push-button conditioner: 2-flop sync, per-channel debounce FSM, registered level/press/release pulses.
// Optional auto-repeat of btn_press while held is enabled with `define AUTOREPEAT_EN.
module button_edge_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             any_press
);

   localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW    = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef AUTOREPEAT_EN
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   logic [N_BTN-1:0] sync1, sync2;
   logic [N_BTN-1:0] press_nx_v;
   logic             any_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_ch
         state_t        state, state_nx;
         logic [CW-1:0] cnt, cnt_nx;
         logic          level_q, press_q, release_q;
         logic          level_nx, press_nx, release_nx;
         logic          s;

         assign s = sync2[i];

`ifdef AUTOREPEAT_EN
         // rpt selects the repeat-period phase once the initial delay has elapsed
         logic rpt, rpt_nx;
         logic rpt_hit;
         assign rpt_hit = (state == HELD) && s && (cnt == (rpt ? RP_LAST : RD_LAST));
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state     <= IDLE;
               cnt       <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
               rpt       <= 1'b0;
`endif
            end else begin
               state     <= state_nx;
               cnt       <= cnt_nx;
               level_q   <= level_nx;
               press_q   <= press_nx;
               release_q <= release_nx;
`ifdef AUTOREPEAT_EN
               rpt       <= rpt_nx;
`endif
            end
         end

         always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
`ifdef AUTOREPEAT_EN
            rpt_nx   = rpt;
`endif
            unique case (state)
               IDLE: begin
                  if (s) begin
                     state_nx = PRESS_WAIT;
                     cnt_nx   = '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!s) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end else if (cnt == DB_LAST) begin
                     state_nx = HELD;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
               HELD: begin
                  if (!s) begin
                     state_nx = RELEASE_WAIT;
                     cnt_nx   = '0;
`ifdef AUTOREPEAT_EN
                     rpt_nx   = 1'b0;
                  end else if (rpt_hit) begin
                     cnt_nx = '0;
                     rpt_nx = 1'b1;
                  end else begin
                     cnt_nx = cnt + CW'(1);
`endif
                  end
               end
               RELEASE_WAIT: begin
                  if (s) begin
                     state_nx = HELD;
                     cnt_nx   = '0;
                  end else if (cnt == DB_LAST) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
               default: begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            endcase
         end

         always_comb begin
            press_nx   = (state == PRESS_WAIT) && s && (cnt == DB_LAST);
`ifdef AUTOREPEAT_EN
            press_nx   = press_nx || rpt_hit;
`endif
            release_nx = (state == RELEASE_WAIT) && !s && (cnt == DB_LAST);
            level_nx   = (state_nx == HELD) || (state_nx == RELEASE_WAIT);
         end

         assign press_nx_v[i]  = press_nx;
         assign btn_level[i]   = level_q;
         assign btn_press[i]   = press_q;
         assign btn_release[i] = release_q;
      end
   endgenerate

   // Built from next-cycle press terms so it lines up with the registered pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) any_q <= 1'b0;
      else        any_q <= |press_nx_v;
   end

   assign any_press = any_q;

endmodule

// File: tb/tb_button_edge_conditioner.sv
// Scoreboard bench for button_edge_conditioner with DEBOUNCE_CYCLES=4; covers AUTOREPEAT_EN when defined.
module tb_button_edge_conditioner;

   localparam int N  = 5;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_raw;
   logic [N-1:0] lvl, prs, rls;
   logic         anyp;

   always #5 clk = ~clk;

   button_edge_conditioner #(
      .N_BTN(N),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_raw(btn_raw),
      .btn_level(lvl),
      .btn_press(prs),
      .btn_release(rls),
      .any_press(anyp)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned  cyc;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic [N-1:0] level;
      logic         any;
   } ev_t;

   ev_t exp_q[$];
   ev_t got_e;
   int  nvec = 0;
   int  nerr = 0;

   function automatic void expect_ev(input int unsigned c, input logic [N-1:0] p,
                                     input logic [N-1:0] r, input logic [N-1:0] lv);
      ev_t e;
      e.cyc = c; e.press = p; e.rel = r; e.level = lv; e.any = |p;
      exp_q.push_back(e);
   endfunction

   // Any pulse on the outputs must match the next expected event exactly
   always @(negedge clk) begin
      if (prs != '0 || rls != '0 || anyp) begin
         nvec++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b any=%b level=%b",
                     cyc, prs, rls, anyp, lvl);
         end else begin
            got_e = exp_q.pop_front();
            if (got_e.cyc != cyc || got_e.press != prs || got_e.rel != rls ||
                got_e.any != anyp || got_e.level != lvl) begin
               nerr++;
               $display("FAIL event got cyc=%0d press=%b release=%b any=%b level=%b, expected cyc=%0d press=%b release=%b any=%b level=%b",
                        cyc, prs, rls, anyp, lvl, got_e.cyc, got_e.press, got_e.rel, got_e.any, got_e.level);
            end
         end
      end
   end

   task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%b expected=%b", name, got, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_level"},   lvl, '0);
      check({name, "_press"},   prs, '0);
      check({name, "_release"}, rls, '0);
      check({name, "_any"},     {4'b0, anyp}, '0);
   endtask

   task automatic hold(input logic [N-1:0] v, input int n);
      btn_raw = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      rst_n   = 1'b0;
      btn_raw = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      hold('0, 3);

      // Single press/release on btn 3: pulse after edge DB+2
      base = cyc;
      expect_ev(base + 7, 5'b01000, '0, 5'b01000);
      hold(5'b01000, 12);
      check("t1_level_high", lvl, 5'b01000);
      base = cyc;
      expect_ev(base + 7, '0, 5'b01000, '0);
      hold('0, 12);
      check("t1_level_low", lvl, '0);

      // Short glitch shorter than the debounce window
      hold(5'b00100, 3);
      hold('0, 10);
      check("t2_glitch_level", lvl, '0);

      // Bounce on press and on release
      base = cyc;
      expect_ev(base + 9, 5'b00100, '0, 5'b00100);
      hold(5'b00100, 1);
      hold('0, 1);
      hold(5'b00100, 12);
      check("t3_level_high", lvl, 5'b00100);
      base = cyc;
      expect_ev(base + 9, '0, 5'b00100, '0);
      hold('0, 1);
      hold(5'b00100, 1);
      hold('0, 12);
      check("t3_level_low", lvl, '0);

      // Simultaneous channels
      base = cyc;
      expect_ev(base + 7, 5'b01100, '0, 5'b01100);
      hold(5'b01100, 12);
      base = cyc;
      expect_ev(base + 7, '0, 5'b01100, '0);
      hold('0, 12);

      // Reset in the middle of PRESS_WAIT, raw held through reset
      hold(5'b00010, 4);
      rst_n = 1'b0;
      #1;
      check_all_zero("t5_in_reset");
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("t5_reset_held");
      rst_n = 1'b1;
      base  = cyc;
      expect_ev(base + 7, 5'b00010, '0, 5'b00010);
      hold(5'b00010, 12);
      base = cyc;
      expect_ev(base + 7, '0, 5'b00010, '0);
      hold('0, 12);

      // Long hold on btn 4: repeats only when auto-repeat is built in
      base = cyc;
      expect_ev(base + 7, 5'b10000, '0, 5'b10000);
`ifdef AUTOREPEAT_EN
      expect_ev(base + 17, 5'b10000, '0, 5'b10000);
      expect_ev(base + 20, 5'b10000, '0, 5'b10000);
      expect_ev(base + 23, 5'b10000, '0, 5'b10000);
      expect_ev(base + 26, 5'b10000, '0, 5'b10000);
      expect_ev(base + 29, 5'b10000, '0, 5'b10000);
      expect_ev(base + 32, 5'b10000, '0, 5'b10000);
`endif
      expect_ev(base + 37, '0, 5'b10000, '0);
      hold(5'b10000, 30);
      hold('0, 15);
      check("t6_level_low", lvl, '0);

      nvec++;
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL missing_events got=%0d pending expected=0 (next at cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
